// File: rtl/float_to_i.sv
// float_to_i: multi-cycle IEEE-754 single to int32 converter, round toward zero
module float_to_i #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, FINISH, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] din, acc, mask;
  logic [4:0] rem, m, k;
  logic [7:0] e;
  logic [22:0] f;
  logic s, left, neg, inv, sticky, norm;
  assign s = din[31];
  assign e = din[30:23];
  assign f = din[22:0];
  assign norm = e >= 8'd127 && e <= 8'd157;
  assign k = e >= 8'd150 ? 5'(e - 8'd150) : 5'(8'd150 - e);
  assign m = rem < 5'(SHIFT_STEP) ? rem : 5'(SHIFT_STEP);
  assign mask = (32'd1 << m) - 32'd1;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == HOLD;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: shift only when a normal operand needs alignment
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = in_valid ? CLASSIFY : IDLE;
      CLASSIFY: state_nx = norm && k != 5'd0 ? SHIFT : FINISH;
      SHIFT:    state_nx = rem == m ? FINISH : SHIFT;
      FINISH:   state_nx = HOLD;
      HOLD:     state_nx = out_ready ? IDLE : HOLD;
      default:  state_nx = IDLE;
    endcase
  end
  // datapath: specials preload acc with the final value and clear neg
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      din <= '0;
      acc <= '0;
      rem <= '0;
      left <= 1'b0;
      neg <= 1'b0;
      inv <= 1'b0;
      sticky <= 1'b0;
      out_data <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) din <= in_data;
        CLASSIFY: begin
          left <= e >= 8'd150;
          rem <= norm ? k : 5'd0;
          neg <= norm & s;
          sticky <= e < 8'd127 && |{e, f};
          inv <= !norm && e >= 8'd127 && !(s && e == 8'd158 && f == 23'd0);
          acc <= e < 8'd127 ? 32'd0 :
                 norm ? {8'd0, 1'b1, f} :
                 (e == 8'd255 && f != 23'd0) ? 32'h7FFF_FFFF :
                 s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        SHIFT: begin
          acc <= left ? acc << m : acc >> m;
          rem <= rem - m;
          sticky <= sticky | (!left && |(acc & mask));
        end
        FINISH: begin
          out_data <= neg ? -acc : acc;
          out_invalid <= inv;
          out_inexact <= sticky;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_float_to_i.sv
// tb_float_to_i: scoreboard bench for float_to_i against an arithmetic model
module tb_float_to_i;
  localparam int STEP = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_invalid, out_inexact, busy;
  logic [31:0] out_data;
  int checks = 0, errors = 0, cyc = 0;
  logic auto_rdy = 0, forced_rdy = 1, seen = 0, hs_q = 0;
  logic [31:0] held_d;
  logic held_v, held_x;
  typedef struct {logic [31:0] x, d; logic inv, inx; int lat, acc;} exp_t;
  exp_t sb[$];

  float_to_i #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid), .out_inexact(out_inexact), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hs_q <= 0;
    else hs_q <= out_valid && out_ready;
  always @(negedge clk) out_ready = auto_rdy ? ($urandom % 4 != 0) : forced_rdy;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", n, a, e, $time);
    end
  endtask

  // value-level reference: |x| = mant * 2^(e-150), truncated toward zero
  function automatic exp_t model(input logic [31:0] x);
    exp_t r;
    longint mant, mag, pw;
    int ex, k;
    logic s;
    s = x[31];
    ex = int'(x[30:23]);
    r.x = x; r.inv = 0; r.inx = 0; r.lat = 2; r.acc = 0;
    mant = longint'(x[22:0]) + (longint'(1) << 23);
    if (ex == 255 && x[22:0] != 0) begin
      r.d = 32'h7FFF_FFFF; r.inv = 1;
    end else if (ex >= 158) begin
      r.d = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r.inv = !(s && ex == 158 && x[22:0] == 0);
    end else if (ex < 127) begin
      r.d = 0; r.inx = x[30:0] != 0;
    end else begin
      k = ex >= 150 ? ex - 150 : 150 - ex;
      pw = longint'(1) << k;
      mag = ex >= 150 ? mant * pw : mant / pw;
      r.inx = ex < 150 && (mant % pw) != 0;
      r.d = 32'(s ? -mag : mag);
      r.lat = 2 + (k + STEP - 1) / STEP;
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] x);
    exp_t r;
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
      return;
    end
    r = model(x);
    r.acc = cyc + 1;
    sb.push_back(r);
    in_valid = 1;
    in_data = x;
    @(negedge clk);
    in_valid = 0;
  endtask

  // monitor: pop on each new result, then watch it stay stable in HOLD
  always @(negedge clk) if (rst_n) begin
    if (hs_q) begin
      chk("post_hs_in_ready", 32'(in_ready), 1);
      chk("post_hs_out_valid", 32'(out_valid), 0);
    end
    if (out_valid) begin
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_busy", 32'(busy), 1);
      if (!seen) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got %h want none", out_data);
        end else begin
          exp_t r;
          r = sb.pop_front();
          chk($sformatf("data[%h]", r.x), out_data, r.d);
          chk($sformatf("invalid[%h]", r.x), 32'(out_invalid), 32'(r.inv));
          chk($sformatf("inexact[%h]", r.x), 32'(out_inexact), 32'(r.inx));
          chk($sformatf("latency[%h]", r.x), 32'(cyc - r.acc), 32'(r.lat));
        end
        held_d = out_data; held_v = out_invalid; held_x = out_inexact;
        seen = 1;
      end else begin
        chk("stable_data", out_data, held_d);
        chk("stable_flags", 32'({out_invalid, out_inexact}), 32'({held_v, held_x}));
      end
    end else seen = 0;
  end

  initial begin
    logic [31:0] dir [11] = '{32'h3F800000, 32'hC0200000, 32'h4EFFFFFF, 32'h4F000000,
      32'hCF000000, 32'h7FC00000, 32'hFF800000, 32'h3F000000, 32'h00000001, 32'h80000000,
      32'h7F800000};
    int w;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", 32'({out_invalid, out_inexact}), 0);
    @(negedge clk);
    rst_n = 1;
    foreach (dir[i]) send(dir[i]);
    repeat (20) @(negedge clk);
    forced_rdy = 0;
    send(32'h4EFFFFFF);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    chk("hold_reached", 32'(out_valid), 1);
    repeat (5) begin
      in_valid = 1;
      in_data = 32'h3F800000;
      @(negedge clk);
    end
    in_valid = 0;
    forced_rdy = 1;
    repeat (20) @(negedge clk);
    send(32'h3F800000);
    @(negedge clk);
    chk("in_shift_busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_flags", 32'({out_invalid, out_inexact}), 0);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    auto_rdy = 1;
    repeat (80) begin
      logic [7:0] e;
      case ($urandom % 8)
        0: e = 8'd255;
        1: e = 8'($urandom_range(0, 126));
        2: e = 8'($urandom_range(158, 160));
        default: e = 8'($urandom_range(127, 157));
      endcase
      send({1'($urandom), e, ($urandom % 5 == 0) ? 23'd0 : 23'($urandom)});
    end
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 500) begin @(negedge clk); w++; end
    chk("drain_queue", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_to_i.md
Name: float_to_i

Overview:
- Multi-cycle converter from IEEE-754 single-precision float to signed 32-bit integer, rounding toward zero (cvt.w.s / trunc.w.s semantics).
- Counterpart of the existing combinational int-to-float block; sits beside it in the FPU execute path.
- The mantissa is aligned by an iterative shifter, trading latency for area. Ready/valid handshake on both sides.

Parameters:
- SHIFT_STEP, 4, maximum bit positions shifted per SHIFT cycle. Legal range 1..23.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter can accept; high only in IDLE
- in_data  in  32  float operand {sign, exp[7:0], frac[22:0]}
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_data  out  32  signed integer result
- out_invalid  out  1  NaN, infinity or out-of-range operand
- out_inexact  out  1  nonzero fraction bits discarded
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_invalid=0, out_inexact=0, busy=0. Internal accumulator, count and sticky bit are cleared.
- States: IDLE -> CLASSIFY -> SHIFT (0..n cycles) -> FINISH -> HOLD -> IDLE.
- IDLE: at a clock edge with in_valid=1, latch in_data and go to CLASSIFY. in_valid is ignored in every other state.
- CLASSIFY (1 cycle): s=in[31], e=in[30:23], f=in[22:0]. Classify by e:
  - e<127 (zero, denormal, |x|<1): result 0, inexact=(e|f)!=0, go to FINISH.
  - e=255 with f!=0 (NaN): result 0x7FFFFFFF, invalid=1, go to FINISH.
  - e>=158 (includes infinity): if s=1, e=158 and f=0, result 0x80000000 with invalid=0. Otherwise saturate: s=0 gives 0x7FFFFFFF, s=1 gives 0x80000000, invalid=1. Go to FINISH.
  - 127<=e<=157: acc = zero-extended {1,f} (32-bit). If e>=150, left shift k=e-150 (0..7). Otherwise right shift k=150-e (1..23). Clear sticky. If k=0 go to FINISH, else go to SHIFT.
- SHIFT: each cycle shift acc by m=min(SHIFT_STEP, remaining) in the chosen direction and subtract m from remaining. On right shifts, OR the discarded bits into sticky. Go to FINISH when remaining reaches 0. Number of SHIFT cycles is n=ceil(k/SHIFT_STEP).
- FINISH: out_data = s ? -acc (two's complement, 32-bit) : acc. For normal operands out_inexact=sticky; special cases use the flags set in CLASSIFY. Set out_valid=1 and go to HOLD.
- Latency: out_valid rises n+2 clock edges after the acceptance edge. n=0 for special cases and k=0.
- Throughput: one conversion in flight. in_ready stays low from acceptance until the edge after the out_valid/out_ready handshake.
- HOLD: out_data, out_invalid and out_inexact stay stable while out_valid=1 and out_ready=0. At an edge with out_ready=1, clear out_valid and go to IDLE. out_data and the flags keep their values until the next FINISH.
- out_ready is ignored when out_valid=0.
- Reset mid-operation: the conversion is discarded immediately with all outputs at reset values. No output appears after rst_n releases.
- Left shifts never overflow: e<=157 bounds the magnitude to under 2^31.

Test Plan:
- 0x3F800000 (1.0), SHIFT_STEP=4, out_ready=1 -> out_data=0x00000001, invalid=0, inexact=0. out_valid rises 8 edges after acceptance (k=23, n=6).
- 0xC0200000 (-2.5) -> out_data=0xFFFFFFFE, inexact=1, invalid=0.
- 0x4EFFFFFF -> out_data=0x7FFFFF80, exact, latency 4 edges (k=7, n=2).
- Range boundaries:
  - 0x4F000000 -> 0x7FFFFFFF with invalid=1.
  - 0xCF000000 -> 0x80000000 with invalid=0.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF with invalid=1.
  - 0xFF800000 (-inf) -> 0x80000000 with invalid=1.
  - Each special case has latency 2.
- 0x3F000000 (0.5) and 0x00000001 (denormal) -> 0x00000000, inexact=1, latency 2. 0x80000000 (-0) -> 0, inexact=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles after out_valid: outputs stable, in_ready=0, and a second in_valid is not accepted.
  - Then assert out_ready: in_ready=1 on the following cycle.
  - Pulse rst_n low during SHIFT: outputs return to reset values asynchronously and no result is emitted.
